// File: rtl/conv_encoder_tx.sv
// Rate-1/2, K=3 convolutional encoder that serializes one parallel word per frame.
// Build option: define CONV_TAIL_EN to append two zero tail symbols for trellis termination.
module conv_encoder_tx #(
    parameter int          SIZE_DATA_IN  = 8,
    parameter int          SIZE_DATA_OUT = 2,
    parameter logic [2:0]  G0            = 3'b111,
    parameter logic [2:0]  G1            = 3'b101,
    parameter bit          MSB_FIRST     = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [SIZE_DATA_IN-1:0]  i_data,
    input  logic                     i_ready,
    output logic [SIZE_DATA_OUT-1:0] o_data,
    output logic                     o_valid,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int CNT_W = $clog2(SIZE_DATA_IN + 1);

    typedef enum logic [1:0] {IDLE, ENC, TAIL, DONE} state_t;

    state_t                   state_reg, state_next;
    logic [SIZE_DATA_IN-1:0]  shift_reg, shift_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;
    logic [1:0]               enc_reg, enc_next;

    logic                     sym_valid;
    logic                     cur_bit;
    logic                     xfer;
    logic                     last_bit;
    logic [2:0]               taps;
    logic [SIZE_DATA_OUT-1:0] sym;

    assign sym_valid = (state_reg == ENC) || (state_reg == TAIL);
    // Tail symbols are encoded with a forced zero input bit.
    assign cur_bit   = (state_reg == ENC) ?
                       (MSB_FIRST ? shift_reg[SIZE_DATA_IN-1] : shift_reg[0]) : 1'b0;
    assign taps      = {cur_bit, enc_reg};
    assign xfer      = sym_valid && i_ready;
    assign last_bit  = (cnt_reg == CNT_W'(SIZE_DATA_IN - 1));

    // Top symbol bit uses G0, the remaining bit uses G1.
    generate
        for (genvar gi = 0; gi < SIZE_DATA_OUT; gi++) begin : gen_poly
            localparam logic [2:0] POLY = (gi == SIZE_DATA_OUT - 1) ? G0 : G1;
            assign sym[gi] = ^(taps & POLY);
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            enc_reg   <= 2'b00;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            enc_reg   <= enc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        enc_next   = enc_reg;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    shift_next = i_data;
                    cnt_next   = '0;
                    enc_next   = 2'b00;
                    state_next = ENC;
                end
            end
            ENC: begin
                if (xfer) begin
                    enc_next   = {cur_bit, enc_reg[1]};
                    shift_next = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
                    if (last_bit) begin
                        cnt_next = '0;
`ifdef CONV_TAIL_EN
                        state_next = TAIL;
`else
                        state_next = DONE;
`endif
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            TAIL: begin
                if (xfer) begin
                    enc_next = {1'b0, enc_reg[1]};
                    if (cnt_reg == CNT_W'(1)) begin
                        cnt_next   = '0;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_valid = sym_valid;
    assign o_busy  = sym_valid;
    assign o_done  = (state_reg == DONE);
    assign o_data  = sym_valid ? sym : '0;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Self-checking bench for conv_encoder_tx: spec vector table, handshake corner cases,
// reset abort, LSB-first instance and randomized frames against a bit-history model.
`timescale 1ns/1ps
module tb_conv_encoder_tx;

`ifdef CONV_TAIL_EN
    localparam int TAIL_LEN = 2;
`else
    localparam int TAIL_LEN = 0;
`endif
    localparam int NBITS = 8;
    localparam int NSYM  = NBITS + TAIL_LEN;
    localparam logic [2:0] G0_T = 3'b111;
    localparam logic [2:0] G1_T = 3'b101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] data = 8'h00;
    logic [1:0] o_data;
    logic       o_valid, o_busy, o_done;

    logic       l_start = 1'b0;
    logic       l_ready = 1'b0;
    logic [7:0] l_din = 8'h00;
    logic [1:0] l_data;
    logic       l_valid, l_busy, l_done;

    always #5 clk = ~clk;

    conv_encoder_tx #(.SIZE_DATA_IN(8), .SIZE_DATA_OUT(2), .G0(3'b111), .G1(3'b101),
                      .MSB_FIRST(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_data(data), .i_ready(ready),
        .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done));

    conv_encoder_tx #(.SIZE_DATA_IN(8), .SIZE_DATA_OUT(2), .G0(3'b111), .G1(3'b101),
                      .MSB_FIRST(1'b0)) dut_lsb (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(l_start), .i_data(l_din), .i_ready(l_ready),
        .o_data(l_data), .o_valid(l_valid), .o_busy(l_busy), .o_done(l_done));

    int n_vec = 0;
    int n_err = 0;
    logic [1:0] got_q[$];
    logic [1:0] exp_q[$];

    typedef struct {
        string       name;
        logic [7:0]  data;
        logic [19:0] syms;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected symbols from the tap definition, using the bit history of the frame.
    function automatic void model(input logic [7:0] d, input bit msb);
        logic b, p1, p2;
        logic [2:0] r;
        exp_q.delete();
        p1 = 1'b0;
        p2 = 1'b0;
        for (int i = 0; i < NSYM; i++) begin
            b = (i < NBITS) ? (msb ? d[NBITS-1-i] : d[i]) : 1'b0;
            r = {b, p1, p2};
            exp_q.push_back({^(r & G0_T), ^(r & G1_T)});
            p2 = p1;
            p1 = b;
        end
    endfunction

    function automatic void table_exp(input logic [19:0] s);
        logic [19:0] v;
        v = s;
        exp_q.delete();
        for (int i = 0; i < NSYM; i++) exp_q.push_back(v[19-2*i -: 2]);
    endfunction

    task automatic cmp_q(input string name);
        int n;
        chk({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_sym%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    // mode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic run_frame(input logic [7:0] d, input int mode, input bit inject);
        bit prev_xfer, held, seen_done;
        logic [1:0] held_sym;
        got_q.delete();
        @(negedge clk);
        start = 1'b1; data = d; ready = 1'b1;
        @(negedge clk);
        start = 1'b0; data = 8'h5A;
        chk("latency_valid", 32'(o_valid), 32'd1);
        chk("latency_busy", 32'(o_busy), 32'd1);
        prev_xfer = 1'b0; held = 1'b0; seen_done = 1'b0; held_sym = 2'b00;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (o_done) begin
                seen_done = 1'b1;
                break;
            end
            if (!o_valid) begin
                chk("no_bubble", 32'(o_valid), 32'd1);
                break;
            end
            if (held) chk("hold_stable", 32'(o_data), 32'(held_sym));
            if (inject && cyc == 3) begin
                start = 1'b1; data = 8'h00;
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       ready = 1'b1;
                1:       ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            prev_xfer = ready;
            if (ready) got_q.push_back(o_data);
            held = !ready;
            held_sym = o_data;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", 32'(seen_done), 32'd1);
        if (seen_done) begin
            chk("done_after_xfer", 32'(prev_xfer), 32'd1);
            chk("done_valid_low", 32'(o_valid), 32'd0);
            chk("done_busy_low", 32'(o_busy), 32'd0);
            @(negedge clk);
            chk("done_one_cycle", 32'(o_done), 32'd0);
        end
    endtask

    initial begin
        bit seen;
        tbl[0] = '{"b0", 8'hB0, 20'b11_10_00_01_01_11_00_00_00_00};
        tbl[1] = '{"ff", 8'hFF, 20'b11_01_10_10_10_10_10_10_01_11};
        tbl[2] = '{"00", 8'h00, 20'b00_00_00_00_00_00_00_00_00_00};
        tbl[3] = '{"01", 8'h01, 20'b00_00_00_00_00_00_00_11_10_11};

        // Reset state, then ready high while idle must not produce anything.
        ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready_valid", 32'(o_valid), 32'd0);

        for (int t = 0; t < 4; t++) begin
            run_frame(tbl[t].data, 0, 1'b0);
            table_exp(tbl[t].syms);
            cmp_q({"tbl_", tbl[t].name});
            $display("frame tbl %s data=%02h symbols=%0d errors=%0d", tbl[t].name, tbl[t].data, got_q.size(), n_err);
        end

        run_frame(8'hB0, 1, 1'b0);
        table_exp(tbl[0].syms);
        cmp_q("backpressure");
        $display("frame backpressure data=b0 symbols=%0d errors=%0d", got_q.size(), n_err);

        run_frame(8'hB0, 0, 1'b1);
        table_exp(tbl[0].syms);
        cmp_q("start_ignored");
        $display("frame start_ignored data=b0 symbols=%0d errors=%0d", got_q.size(), n_err);

        // Abort after the third transfer.
        @(negedge clk);
        start = 1'b1; data = 8'hB0; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_sym", 32'(o_data), 32'b01);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_data", 32'(o_data), 32'd0);
        @(negedge clk);
        chk("abort_no_done", 32'(o_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_after_done", 32'(o_done), 32'd0);
        chk("abort_after_valid", 32'(o_valid), 32'd0);
        run_frame(8'hB0, 0, 1'b0);
        table_exp(tbl[0].syms);
        cmp_q("after_abort");
        $display("frame after_abort data=b0 symbols=%0d errors=%0d", got_q.size(), n_err);

        // LSB-first instance: 8'h0D serializes to the same bits as 8'hB0.
        got_q.delete();
        seen = 1'b0;
        @(negedge clk);
        l_start = 1'b1; l_din = 8'h0D; l_ready = 1'b1;
        @(negedge clk);
        l_start = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (l_done) begin
                seen = 1'b1;
                break;
            end
            if (l_valid) got_q.push_back(l_data);
            @(negedge clk);
        end
        chk("lsb_done_seen", 32'(seen), 32'd1);
        table_exp(tbl[0].syms);
        cmp_q("lsb_first");
        $display("frame lsb_first data=0d symbols=%0d errors=%0d", got_q.size(), n_err);

        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            int m;
            d = 8'($urandom);
            m = int'($urandom_range(0, 2));
            run_frame(d, m, 1'b0);
            model(d, 1'b1);
            cmp_q($sformatf("rand%0d", k));
            $display("frame rand%0d data=%02h mode=%0d symbols=%0d errors=%0d", k, d, m, got_q.size(), n_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_encoder_tx.md
Name: conv_encoder_tx

Overview:
- Rate-1/2, K=3 convolutional encoder with a parallel-word front end. It is the transmit-side counterpart of the Viterbi decoder.
- Accepts one SIZE_DATA_IN-bit word per frame and serializes it bit by bit.
- Emits one 2-bit coded symbol per accepted input bit, under a valid/ready handshake.
- Output drives the decoder's 2-bit symbol input directly, or feeds a channel/PISO path in loopback test builds.

Parameters:
- SIZE_DATA_IN, 8, information bits per frame (≥1)
- SIZE_DATA_OUT, 2, coded symbol width (fixed at 2; other values unsupported)
- G0, 3'b111, generator polynomial for o_data[1]; bit2 = current input bit
- G1, 3'b101, generator polynomial for o_data[0]
- MSB_FIRST, 1, 1 = encode i_data MSB first; 0 = LSB first

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  frame start request; sampled only in IDLE
- i_data  input  SIZE_DATA_IN  frame word; captured on an accepted i_start
- i_ready  input  1  downstream accepts the current symbol
- o_data  output  SIZE_DATA_OUT  coded symbol {g0, g1}
- o_valid  output  1  o_data is valid; held until accepted
- o_busy  output  1  high from the cycle after an accepted i_start until o_done
- o_done  output  1  one-cycle pulse after the last symbol is accepted

Behaviour:
- Clock and reset: single clock domain, i_clk. Reset is asynchronous and active-low on i_rst_n. While reset is asserted:
  - all outputs are 0; FSM = IDLE; shift register, encoder state and counters cleared.
- Encoder core:
  - State is s[1:0], where s[1] = previous bit and s[0] = the bit before that.
  - Each symbol uses the tap vector r = {b, s[1], s[0]}.
  - o_data[1] = ^(r & G0); o_data[0] = ^(r & G1).
  - After a symbol is accepted: s <= {b, s[1]}.
  - Encoder state is cleared to 00 at every accepted i_start (zero-start frames).
- Handshake:
  - A symbol transfers on a cycle where o_valid && i_ready.
  - o_valid, once high, stays high with o_data stable until the transfer.
  - No bubble between consecutive symbols of a frame: the next symbol is presented on the cycle after the transfer.
- FSM states: IDLE, ENC, TAIL, DONE.
  - IDLE: when i_start=1:
    - capture i_data into the shift register; bit counter <= 0;
    - next cycle: o_valid=1 with symbol 0, o_busy=1, go to ENC.
    - Latency from i_start to first valid symbol: 1 cycle.
  - ENC: on each transfer, advance the bit counter.
    - After transfer of bit SIZE_DATA_IN-1: go to TAIL if CONV_TAIL_EN is defined, else go to DONE.
  - TAIL: emit 2 symbols with b=0. Go to DONE after the second transfer.
  - DONE: o_valid=0, o_busy=0, o_done=1 for exactly this cycle; go to IDLE.
    - Earliest i_start for the next frame is the following cycle.
- Boundary conditions:
  - i_start outside IDLE: ignored; i_data is not resampled.
  - i_ready held low indefinitely: symbol held and encoder state frozen.
  - i_ready high while o_valid=0: no effect.
  - i_start and i_ready both high in IDLE: only the start is acted on.
  - Reset mid-frame: frame aborted immediately; no o_done.
  - Counter width: $clog2(SIZE_DATA_IN+1) bits. No wrap within a frame.

Optional Feature:
- Macro: CONV_TAIL_EN.
- Defined: 2 zero tail bits are appended after the data, so each frame is SIZE_DATA_IN+2 symbols and ends in encoder state 00. This is the trellis termination the decoder relies on for a clean traceback.
- Undefined: each frame is exactly SIZE_DATA_IN symbols with no tail. Final encoder state is discarded; the next frame still starts from 00.

Test Plan:
- Basic frame, tail on: i_data=8'hB0, MSB_FIRST=1, i_ready=1. Required symbols: 11,10,00,01,01,11,00,00 then tail 00,00. o_done pulses 1 cycle after the 10th transfer; o_valid is contiguous for 10 cycles.
- All ones, tail on: i_data=8'hFF. Required symbols: 11,01,10,10,10,10,10,10 then tail 01,11.
- Tail off: CONV_TAIL_EN undefined, i_data=8'hFF → exactly 8 symbols (the first 8 above), then o_done.
- Backpressure: 8'hB0 with i_ready toggling 1,0,0,1,… → o_data is stable while i_ready=0. Symbol sequence is identical to the first test; the number of symbols is unchanged.
- Start ignored / reset abort:
  - i_start pulsed with 8'h00 during ENC → current frame continues unchanged.
  - i_rst_n asserted after the 3rd transfer → o_valid, o_busy and o_data are 0 immediately; no o_done.
  - A new 8'hB0 frame after release reproduces the first-test sequence.
- LSB first: MSB_FIRST=0, i_data=8'h0D (bits 1,0,1,1,0,0,0,0) → same symbol sequence as the first test.
